// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmitter slice.
package morse_pkg;

  typedef enum logic [1:0] {IDLE, MARK, GAP, LGAP} state_e;

  localparam int unsigned MAX_LEN  = 4;
  localparam logic        SYM_DOT  = 1'b0;
  localparam logic        SYM_DASH = 1'b1;

endpackage

// File: rtl/morse_timer.sv
// Loadable down-counter; tc_o flags the final cycle of a loaded interval (count == 1).
module morse_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q > WIDTH'(1)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/morse_tx.sv
// Morse letter player: one latched letter (code + length) out on a single LED.
// Optional inter-letter gap enabled by defining MORSE_TX_LETTER_GAP_EN.
module morse_tx
  import morse_pkg::*;
#(
  parameter int unsigned DOT_CYCLES = 25_000_000,
  parameter int unsigned DASH_MULT  = 3,
  parameter int unsigned GAP_CYCLES = 25_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] code_i,
  input  logic [2:0] len_i,
  output logic       led_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned DASH_CYCLES = DASH_MULT * DOT_CYCLES;
  localparam int unsigned LGAP_CYCLES = 3 * DOT_CYCLES;
  // Timer must hold the longest interval it is ever loaded with, not just a dash.
  localparam int unsigned MAX_A   = (DASH_CYCLES > GAP_CYCLES) ? DASH_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > LGAP_CYCLES) ? MAX_A : LGAP_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);

  state_e          state_q, state_d;
  logic [3:0]      code_q, code_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            led_q, led_d;
  logic            done_q, done_d;
  logic [2:0]      eff_len;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_tc;

  function automatic logic [TW-1:0] sym_len(input logic sym);
    logic [TW-1:0] v;
    case (sym)
      SYM_DOT:  v = TW'(DOT_CYCLES);
      SYM_DASH: v = TW'(DASH_CYCLES);
      default:  v = TW'(DOT_CYCLES);
    endcase
    return v;
  endfunction

  assign eff_len = (len_i > 3'(MAX_LEN)) ? 3'(MAX_LEN) : len_i;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (eff_len != 3'd0) begin
            code_d   = code_i;
            cnt_d    = eff_len;
            tmr_load = 1'b1;
            tmr_val  = sym_len(code_i[0]);
            state_d  = MARK;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      MARK: begin
        if (tmr_tc) begin
          if (cnt_q > 3'd1) begin
            code_d   = {1'b0, code_q[3:1]};
            cnt_d    = cnt_q - 3'd1;
            tmr_load = 1'b1;
            tmr_val  = TW'(GAP_CYCLES);
            state_d  = GAP;
          end else begin
            cnt_d = '0;
`ifdef MORSE_TX_LETTER_GAP_EN
            tmr_load = 1'b1;
            tmr_val  = TW'(LGAP_CYCLES);
            state_d  = LGAP;
`else
            done_d  = 1'b1;
            state_d = IDLE;
`endif
          end
        end
      end
      GAP: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          tmr_val  = sym_len(code_q[0]);
          state_d  = MARK;
        end
      end
      LGAP: begin
`ifdef MORSE_TX_LETTER_GAP_EN
        if (tmr_tc) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    led_d = (state_d == MARK);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  morse_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (tmr_load),
    .value_i(tmr_val),
    .tc_o   (tmr_tc)
  );

  assign led_o  = led_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_morse_tx.sv
// Self-checking bench for morse_tx with short timing (dot=2, dash=6, gap=2).
module tb_morse_tx;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [3:0] code_i = '0;
  logic [2:0] len_i = '0;
  logic       led_o, busy_o, done_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Expected {led, busy, done} per cycle; an empty queue means the model is idle.
  logic [2:0] exp_q[$];

  typedef struct {
    logic [3:0]  code;
    logic [2:0]  len;
    int unsigned idle_after;
    bit          poke_busy;
  } vec_t;

  vec_t vecs[8];

  morse_tx #(
    .DOT_CYCLES(2),
    .DASH_MULT (3),
    .GAP_CYCLES(2)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .start_i(start_i),
    .code_i (code_i),
    .len_i  (len_i),
    .led_o  (led_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk = ~clk;

  task automatic push_letter(input logic [3:0] c, input logic [2:0] l);
    int unsigned eff;
    eff = (l > 3'd4) ? 4 : int'(l);
    if (eff == 0) begin
      exp_q.push_back(3'b001);
    end else begin
      for (int unsigned i = 0; i < eff; i++) begin
        repeat (c[i] ? 6 : 2) exp_q.push_back(3'b110);
        if (i < eff - 1) repeat (2) exp_q.push_back(3'b010);
      end
`ifdef MORSE_TX_LETTER_GAP_EN
      repeat (6) exp_q.push_back(3'b010);
`endif
      exp_q.push_back(3'b001);
    end
  endtask

  // Drive inputs for one clock edge, then check outputs at the following negedge.
  task automatic tick(input logic st, input logic [3:0] c, input logic [2:0] l,
                      input logic r, input string name);
    logic [2:0] e;
    logic [2:0] act;
    start_i = st;
    code_i  = c;
    len_i   = l;
    rst_i   = r;
    if (r) begin
      exp_q.delete();
      exp_q.push_back(3'b000);
    end else if (exp_q.size() == 0) begin
      if (st) push_letter(c, l);
      else exp_q.push_back(3'b000);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    rst_i   = 1'b0;
    @(negedge clk);
    e   = exp_q.pop_front();
    act = {led_o, busy_o, done_o};
    n_checks++;
    if (act !== e) begin
      n_errors++;
      $display("FAIL %s t=%0t {led,busy,done} got=%b expected=%b", name, $time, act, e);
    end
  endtask

  initial begin
    vecs[0] = '{code: 4'b0010, len: 3'd2, idle_after: 2, poke_busy: 1'b0}; // A
    vecs[1] = '{code: 4'b0001, len: 3'd4, idle_after: 0, poke_busy: 1'b1}; // B
    vecs[2] = '{code: 4'b1111, len: 3'd0, idle_after: 0, poke_busy: 1'b0}; // empty
    vecs[3] = '{code: 4'b1111, len: 3'd7, idle_after: 1, poke_busy: 1'b1}; // clamp
    vecs[4] = '{code: 4'b0101, len: 3'd5, idle_after: 0, poke_busy: 1'b0};
    vecs[5] = '{code: 4'b0000, len: 3'd1, idle_after: 1, poke_busy: 1'b0};
    vecs[6] = '{code: 4'b1001, len: 3'd1, idle_after: 0, poke_busy: 1'b1};
    vecs[7] = '{code: 4'b0110, len: 3'd3, idle_after: 2, poke_busy: 1'b0};

    repeat (3) tick(1'b0, 4'h0, 3'd0, 1'b1, "reset");
    repeat (2) tick(1'b0, 4'h0, 3'd0, 1'b0, "idle_after_reset");

    for (int unsigned v = 0; v < 8; v++) begin
      int unsigned steps;
      tick(1'b1, vecs[v].code, vecs[v].len, 1'b0, $sformatf("vec%0d_start", v));
      steps = 0;
      while (exp_q.size() != 0 && steps < 100) begin
        if (vecs[v].poke_busy && steps == 3)
          tick(1'b1, ~vecs[v].code, 3'd4, 1'b0, $sformatf("vec%0d_busy_start", v));
        else
          tick(1'b0, $urandom_range(15, 0), $urandom_range(7, 0), 1'b0,
               $sformatf("vec%0d_run", v));
        steps++;
      end
      repeat (vecs[v].idle_after) tick(1'b0, 4'h0, 3'd0, 1'b0, $sformatf("vec%0d_idle", v));
    end

    // Reset partway through letter A, then a fresh start.
    tick(1'b1, 4'b0010, 3'd2, 1'b0, "rst_mid_start");
    repeat (3) tick(1'b0, 4'h0, 3'd0, 1'b0, "rst_mid_run");
    tick(1'b0, 4'h0, 3'd0, 1'b1, "rst_mid_abort");
    tick(1'b0, 4'h0, 3'd0, 1'b0, "rst_mid_idle");
    tick(1'b1, 4'b0001, 3'd1, 1'b0, "rst_mid_restart");
    for (int unsigned k = 0; k < 20 && exp_q.size() != 0; k++)
      tick(1'b0, 4'h0, 3'd0, 1'b0, "rst_mid_after");

    // Zero-length request immediately followed by a real letter in the done cycle.
    tick(1'b1, 4'b0000, 3'd0, 1'b0, "zero_len");
    tick(1'b1, 4'b0011, 3'd2, 1'b0, "zero_then_start");
    for (int unsigned k = 0; k < 40 && exp_q.size() != 0; k++)
      tick(1'b0, 4'h0, 3'd0, 1'b0, "zero_then_run");
    repeat (2) tick(1'b0, 4'h0, 3'd0, 1'b0, "final_idle");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
